// File: rtl/dino_pkg.sv
// rtl/dino_pkg.sv - shared encodings and helpers for the dino obstacle pipeline
package dino_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_ISSUE = 2'd2
    } spawn_state_e;

    localparam logic [1:0] OBS_SMALL = 2'd0;
    localparam logic [1:0] OBS_LARGE = 2'd1;
    localparam logic [1:0] OBS_BIRD  = 2'd2;

    localparam int DEF_MIN_GAP    = 40;
    localparam int DEF_GAP_FLOOR  = 24;
    localparam int DEF_FIRST_GAP  = 60;
    localparam int DEF_BIRD_LEVEL = 3;

    // Birds are only unlocked at higher levels; otherwise the bird slot becomes a large cactus.
    function automatic logic [1:0] select_type(input logic [1:0] sel, input logic bird_ok);
        logic [1:0] t;
        case (sel)
            2'b00, 2'b01: t = OBS_SMALL;
            2'b10:        t = OBS_LARGE;
            default:      t = bird_ok ? OBS_BIRD : OBS_LARGE;
        endcase
        return t;
    endfunction

    function automatic logic [1:0] bird_lane(input logic [1:0] r);
        return (r == 2'd3) ? 2'd1 : r;
    endfunction

endpackage

// File: rtl/obstacle_gap_calc.sv
// rtl/obstacle_gap_calc.sv - level-scaled random spawn gap with a floor
module obstacle_gap_calc #(
    parameter int MIN_GAP   = 40,
    parameter int GAP_FLOOR = 24
) (
    input  logic [5:0] rnd,
    input  logic [3:0] level,
    output logic [7:0] gap
);

    logic [8:0] raw;
    logic [8:0] sub;
    logic [8:0] lim;
    logic [7:0] diff;

    assign raw  = 9'(MIN_GAP) + {3'b000, rnd};
    assign sub  = {4'b0000, level, 1'b0};
    assign lim  = sub + 9'(GAP_FLOOR);
    // raw never exceeds 255 because MIN_GAP is bounded, so the 8-bit difference is exact.
    assign diff = raw[7:0] - sub[7:0];

    always_comb begin
        gap = diff;
        if (raw < lim) begin
            gap = 8'(GAP_FLOOR);
        end
    end

endmodule

// File: rtl/obstacle_spawner.sv
// rtl/obstacle_spawner.sv - turns LFSR bytes into timed obstacle spawn requests
module obstacle_spawner
    import dino_pkg::*;
#(
    parameter int MIN_GAP    = DEF_MIN_GAP,
    parameter int GAP_FLOOR  = DEF_GAP_FLOOR,
    parameter int FIRST_GAP  = DEF_FIRST_GAP,
    parameter int BIRD_LEVEL = DEF_BIRD_LEVEL
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       tick,
    input  logic [3:0] level,
    input  logic [7:0] rnd,
    input  logic       spawn_ready,
    output logic       spawn_valid,
    output logic [1:0] spawn_type,
    output logic [1:0] spawn_height,
    output logic [7:0] spawn_count
);

    spawn_state_e state_q, state_d;
    logic [7:0]   gap_q, gap_d;
    logic         valid_q, valid_d;
    logic [1:0]   type_q, type_d;
    logic [1:0]   height_q, height_d;
    logic [7:0]   count_q, count_d;
    logic [7:0]   next_gap;
    logic         bird_ok;
    logic [1:0]   sel_type;

    obstacle_gap_calc #(
        .MIN_GAP   (MIN_GAP),
        .GAP_FLOOR (GAP_FLOOR)
    ) u_gap_calc (
        .rnd   (rnd[5:0]),
        .level (level),
        .gap   (next_gap)
    );

    assign bird_ok  = (level >= 4'(BIRD_LEVEL));
    assign sel_type = select_type(rnd[7:6], bird_ok);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            gap_q    <= 8'd0;
            valid_q  <= 1'b0;
            type_q   <= OBS_SMALL;
            height_q <= 2'd0;
            count_q  <= 8'd0;
        end else begin
            state_q  <= state_d;
            gap_q    <= gap_d;
            valid_q  <= valid_d;
            type_q   <= type_d;
            height_q <= height_d;
            count_q  <= count_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        gap_d    = gap_q;
        valid_d  = valid_q;
        type_d   = type_q;
        height_d = height_q;
        count_d  = count_q;

        // Leaving the game discards any pending request, even one being accepted this edge.
        if (!run) begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_WAIT;
                    gap_d   = 8'(FIRST_GAP);
                    count_d = 8'd0;
                end
                ST_WAIT: begin
                    if (tick) begin
                        if (gap_q > 8'd1) begin
                            gap_d = gap_q - 8'd1;
                        end else begin
                            state_d  = ST_ISSUE;
                            valid_d  = 1'b1;
                            type_d   = sel_type;
                            height_d = (sel_type == OBS_BIRD) ? bird_lane(rnd[1:0]) : 2'd0;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (valid_q && spawn_ready) begin
                        state_d = ST_WAIT;
                        valid_d = 1'b0;
                        gap_d   = next_gap;
                        if (count_q != 8'hFF) begin
                            count_d = count_q + 8'd1;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    assign spawn_valid  = valid_q;
    assign spawn_type   = type_q;
    assign spawn_height = height_q;
    assign spawn_count  = count_q;

endmodule
